exc_ctrl: RTL and testbench

Pipeline exception/interrupt controller that sequences the CP0 register file and the pipeline registers.
- Evaluates MEM-stage exception flags and pending interrupts against forwarded Status/Cause/EPC.
- Picks one event by fixed priority and drives the 32-bit exception type into CP0.
- Waits for any outstanding AXI-Lite data transaction to drain, then flushes the pipeline and supplies the redirect PC.
- Also merges per-stage stall requests into the 6-bit stall vector.

---
 rtl/exc_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_exc_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: pipeline exception/interrupt controller.
// Evaluates MEM-stage exception flags and pending interrupts against
// forwarded CP0 Status/Cause/EPC, picks one event by fixed priority,
// waits for the data bus to drain, then flushes and redirects the PC.
// It also merges per-stage stall requests into the 6-bit hold vector.
// Optional feature: define EXC_TIMER_IRQ_EN to OR timer_irq_i into Cause[15].
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          DRAIN_MAX  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  exc_flags_i,
  input  logic        mem_valid_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        cp0_wen_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic        timer_irq_i,
  input  logic        bus_busy_i,
  input  logic [3:0]  stall_req_i,
  output logic [31:0] exception_type_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [5:0]  stall_o,
  output logic        bus_abort_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] DRAIN_LIMIT = 8'(DRAIN_MAX);

  logic [1:0]  state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] code_reg, code_next;
  logic [31:0] target_reg, target_next;
  logic        abort_reg, abort_next;

  logic [31:0] status_fwd, cause_fwd, epc_fwd;
  logic        irq_pending;
  logic [31:0] evt_code, evt_target;
  logic        evt_valid;
  logic [5:0]  stall_merge;
  logic        unused_bits;

  // Bypass the WB-stage CP0 write so decisions see the newest register values.
  always_comb begin
    status_fwd = status_i;
    cause_fwd  = cause_i;
    epc_fwd    = epc_i;
    if (cp0_wen_i) begin
      case (cp0_waddr_i)
        5'd12: status_fwd = cp0_wdata_i;
        5'd13: begin
          // Only the software-writable Cause fields are replaced.
          cause_fwd[9:8]   = cp0_wdata_i[9:8];
          cause_fwd[23:22] = cp0_wdata_i[23:22];
        end
        5'd14: epc_fwd = cp0_wdata_i;
        default: ;
      endcase
    end
`ifdef EXC_TIMER_IRQ_EN
    cause_fwd[15] = cause_fwd[15] | timer_irq_i;
`endif
  end

`ifdef EXC_TIMER_IRQ_EN
  assign unused_bits = ^{status_fwd[31:16], status_fwd[7:2], cause_fwd[31:16], cause_fwd[7:0]};
`else
  // Timer input is intentionally ignored in this build.
  assign unused_bits = ^{status_fwd[31:16], status_fwd[7:2], cause_fwd[31:16], cause_fwd[7:0],
                         timer_irq_i};
`endif

  assign irq_pending = (|(cause_fwd[15:8] & status_fwd[15:8])) && status_fwd[0] &&
                       !status_fwd[1] && mem_valid_i;

  // Fixed-priority event selection and redirect target.
  always_comb begin
    evt_code = 32'h0;
    if (irq_pending)                         evt_code = 32'h1;
    else if (mem_valid_i && exc_flags_i[1]) evt_code = 32'ha;
    else if (mem_valid_i && exc_flags_i[3]) evt_code = 32'hc;
    else if (mem_valid_i && exc_flags_i[2]) evt_code = 32'hd;
    else if (mem_valid_i && exc_flags_i[0]) evt_code = 32'h8;
    else if (mem_valid_i && exc_flags_i[4]) evt_code = 32'he;
    evt_valid  = (evt_code != 32'h0);
    evt_target = (evt_code == 32'he) ? epc_fwd : EXC_VECTOR;
  end

  // Deepest requesting stage freezes itself and everything upstream.
  always_comb begin
    stall_merge = 6'b000000;
    if (stall_req_i[3])      stall_merge = 6'b011111;
    else if (stall_req_i[2]) stall_merge = 6'b001111;
    else if (stall_req_i[1]) stall_merge = 6'b000111;
    else if (stall_req_i[0]) stall_merge = 6'b000011;
  end

  // Sequencing FSM: next-state logic and Mealy outputs.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    code_next        = code_reg;
    target_next      = target_reg;
    abort_next       = 1'b0;
    exception_type_o = 32'h0;
    flush_o          = 1'b0;
    new_pc_o         = 32'h0;
    bus_abort_o      = 1'b0;
    stall_o          = stall_merge;
    case (state_reg)
      ST_IDLE: begin
        if (evt_valid) begin
          if (!bus_busy_i) begin
            exception_type_o = evt_code;
            flush_o          = 1'b1;
            new_pc_o         = evt_target;
            state_next       = ST_GAP;
          end else begin
            // Freeze the decision so it survives input changes while draining.
            code_next   = evt_code;
            target_next = evt_target;
            cnt_next    = 8'd0;
            state_next  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        stall_o  = 6'b011111;
        cnt_next = cnt_reg + 8'd1;
        // After an abort pulse the bus is considered released.
        if (!bus_busy_i || abort_reg) begin
          exception_type_o = code_reg;
          flush_o          = 1'b1;
          new_pc_o         = target_reg;
          state_next       = ST_GAP;
        end else if (cnt_reg == DRAIN_LIMIT) begin
          bus_abort_o = 1'b1;
          abort_next  = 1'b1;
        end
      end
      ST_GAP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush_o) stall_o = 6'b000000;
    // Outputs are held quiet for as long as reset is asserted.
    if (rst) begin
      exception_type_o = 32'h0;
      flush_o          = 1'b0;
      new_pc_o         = 32'h0;
      bus_abort_o      = 1'b0;
      stall_o          = 6'b000000;
    end
  end

  assign busy_o = (state_reg != ST_IDLE);

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 8'd0;
      code_reg   <= 32'h0;
      target_reg <= 32'h0;
      abort_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      code_reg   <= code_next;
      target_reg <= target_next;
      abort_reg  <= abort_next;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl (DRAIN_MAX overridden to 4).
// Table-driven single-event vectors plus hand-written multi-cycle sequences.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  exc_flags_i;
  logic        mem_valid_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        cp0_wen_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic        timer_irq_i;
  logic        bus_busy_i;
  logic [3:0]  stall_req_i;
  logic [31:0] exception_type_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [5:0]  stall_o;
  logic        bus_abort_o;
  logic        busy_o;

  always #5 clk = ~clk;

  exc_ctrl #(.DRAIN_MAX(4)) dut (
    .clk(clk), .rst(rst), .exc_flags_i(exc_flags_i), .mem_valid_i(mem_valid_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .cp0_wen_i(cp0_wen_i),
    .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i), .timer_irq_i(timer_irq_i),
    .bus_busy_i(bus_busy_i), .stall_req_i(stall_req_i), .exception_type_o(exception_type_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_o(stall_o), .bus_abort_o(bus_abort_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] etype;
    logic        flush;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        abort;
    logic        busy;
  } exp_t;

  typedef struct {
    logic [4:0]  flags;
    logic        mv;
    logic [31:0] status, cause, epc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        timer;
    logic [3:0]  sreq;
    logic [31:0] etype;
    logic        flush;
    logic [31:0] pc;
    logic [5:0]  stall;
  } vec_t;

  exp_t sb[$];
  vec_t vq[$];
  int   total  = 0;
  int   passed = 0;

  function automatic exp_t ex(input logic [31:0] t, input logic f, input logic [31:0] pc,
                              input logic [5:0] st, input logic ab, input logic bz);
    exp_t e;
    e.etype = t; e.flush = f; e.pc = pc; e.stall = st; e.abort = ab; e.busy = bz;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [4:0] fl, input logic mv, input logic [31:0] st,
                               input logic [31:0] ca, input logic [31:0] ep, input logic wen,
                               input logic [4:0] wa, input logic [31:0] wd, input logic tm,
                               input logic [3:0] sr, input logic [31:0] t, input logic f,
                               input logic [31:0] pc, input logic [5:0] stl);
    vec_t v;
    v.flags = fl; v.mv = mv; v.status = st; v.cause = ca; v.epc = ep; v.wen = wen;
    v.waddr = wa; v.wdata = wd; v.timer = tm; v.sreq = sr; v.etype = t; v.flush = f;
    v.pc = pc; v.stall = stl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
  endtask

  // Push the expectation, sample mid-cycle, pop and compare, advance to next drive point.
  task automatic cyc(input string nm, input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk({nm, ".type"},  exception_type_o,        x.etype);
    chk({nm, ".flush"}, {31'b0, flush_o},        {31'b0, x.flush});
    chk({nm, ".pc"},    new_pc_o,                x.pc);
    chk({nm, ".stall"}, {26'b0, stall_o},        {26'b0, x.stall});
    chk({nm, ".abort"}, {31'b0, bus_abort_o},    {31'b0, x.abort});
    chk({nm, ".busy"},  {31'b0, busy_o},         {31'b0, x.busy});
    $display("txn %s: type=%h flush=%b pc=%h stall=%b abort=%b busy=%b",
             nm, exception_type_o, flush_o, new_pc_o, stall_o, bus_abort_o, busy_o);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_flags_i = 5'b0; mem_valid_i = 1'b0; status_i = 32'h0; cause_i = 32'h0;
    epc_i = 32'h0; cp0_wen_i = 1'b0; cp0_waddr_i = 5'd0; cp0_wdata_i = 32'h0;
    timer_irq_i = 1'b0; stall_req_i = 4'b0;
  endtask

  task automatic apply(input vec_t v);
    exc_flags_i = v.flags; mem_valid_i = v.mv; status_i = v.status; cause_i = v.cause;
    epc_i = v.epc; cp0_wen_i = v.wen; cp0_waddr_i = v.waddr; cp0_wdata_i = v.wdata;
    timer_irq_i = v.timer; stall_req_i = v.sreq;
  endtask

  initial begin
    exp_t z;
    z = ex(32'h0, 1'b0, 32'h0, 6'b0, 1'b0, 1'b0);

    // Single-cycle vectors, bus idle, FSM in IDLE.
    vq.push_back(mkv(5'b00010, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'ha, 1, VEC, 6'b0));
    vq.push_back(mkv(5'b01000, 1, 32'hFF01, 32'h400, 32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'h1, 1, VEC, 6'b0));
    vq.push_back(mkv(5'b10000, 1, 32'h0,    32'h0,   32'h80001000, 1, 5'd14, 32'h80002000, 0, 4'b0000, 32'he, 1, 32'h80002000, 6'b0));
    vq.push_back(mkv(5'b10000, 1, 32'h0,    32'h0,   32'h80001000, 0, 5'd14, 32'h80002000, 0, 4'b0000, 32'he, 1, 32'h80001000, 6'b0));
    vq.push_back(mkv(5'b00101, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'hd, 1, VEC, 6'b0));
    vq.push_back(mkv(5'b01010, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'ha, 1, VEC, 6'b0));
    vq.push_back(mkv(5'b01100, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'hc, 1, VEC, 6'b0));
    vq.push_back(mkv(5'b10001, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'h8, 1, VEC, 6'b0));
    vq.push_back(mkv(5'b00010, 0, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'h0, 0, 32'h0, 6'b0));
    vq.push_back(mkv(5'b00000, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b0110, 32'h0, 0, 32'h0, 6'b001111));
    vq.push_back(mkv(5'b00000, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b1000, 32'h0, 0, 32'h0, 6'b011111));
    vq.push_back(mkv(5'b00000, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b0010, 32'h0, 0, 32'h0, 6'b000111));
    vq.push_back(mkv(5'b00000, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b0001, 32'h0, 0, 32'h0, 6'b000011));
    vq.push_back(mkv(5'b01000, 1, 32'h0,    32'h0,   32'h0,        0, 5'd0,  32'h0,        0, 4'b1111, 32'hc, 1, VEC, 6'b0));
    vq.push_back(mkv(5'b00000, 1, 32'hFF03, 32'h400, 32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'h0, 0, 32'h0, 6'b0));
    vq.push_back(mkv(5'b00000, 1, 32'hFF00, 32'h400, 32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'h0, 0, 32'h0, 6'b0));
    vq.push_back(mkv(5'b00000, 1, 32'h0,    32'h400, 32'h0,        1, 5'd12, 32'hFF01,     0, 4'b0000, 32'h1, 1, VEC, 6'b0));
    vq.push_back(mkv(5'b00000, 1, 32'hFF01, 32'h0,   32'h0,        1, 5'd13, 32'h100,      0, 4'b0000, 32'h1, 1, VEC, 6'b0));
    vq.push_back(mkv(5'b00000, 1, 32'hFF01, 32'h0,   32'h0,        1, 5'd13, 32'h400,      0, 4'b0000, 32'h0, 0, 32'h0, 6'b0));
    vq.push_back(mkv(5'b00000, 0, 32'hFF01, 32'h400, 32'h0,        0, 5'd0,  32'h0,        0, 4'b0000, 32'h0, 0, 32'h0, 6'b0));
`ifdef EXC_TIMER_IRQ_EN
    vq.push_back(mkv(5'b00000, 1, 32'h8001, 32'h0,   32'h0,        0, 5'd0,  32'h0,        1, 4'b0000, 32'h1, 1, VEC, 6'b0));
`else
    vq.push_back(mkv(5'b00000, 1, 32'h8001, 32'h0,   32'h0,        0, 5'd0,  32'h0,        1, 4'b0000, 32'h0, 0, 32'h0, 6'b0));
`endif

    // Reset: outputs quiet even with an event presented.
    rst = 1'b1; bus_busy_i = 1'b0; clear_inputs();
    exc_flags_i = 5'b00010; mem_valid_i = 1'b1;
    @(posedge clk); #1;
    cyc("reset", z);
    rst = 1'b0; clear_inputs();

    // Table: each vector, then one recovery cycle (GAP after a flush).
    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
      cyc($sformatf("vec%0d", i), ex(vq[i].etype, vq[i].flush, vq[i].pc, vq[i].stall, 1'b0, 1'b0));
      clear_inputs();
      cyc($sformatf("vec%0d_next", i), ex(32'h0, 1'b0, 32'h0, 6'b0, 1'b0, vq[i].flush));
    end

    // GAP masks an event held into the following cycle.
    exc_flags_i = 5'b00010; mem_valid_i = 1'b1;
    cyc("gap_fire", ex(32'ha, 1'b1, VEC, 6'b0, 1'b0, 1'b0));
    cyc("gap_mask", ex(32'h0, 1'b0, 32'h0, 6'b0, 1'b0, 1'b1));
    clear_inputs();
    cyc("gap_idle", z);

    // Overflow while the bus drains for three cycles.
    exc_flags_i = 5'b01000; mem_valid_i = 1'b1; bus_busy_i = 1'b1;
    cyc("drain_enter", z);
    clear_inputs();
    for (int i = 0; i < 3; i++)
      cyc($sformatf("drain_hold%0d", i), ex(32'h0, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b1));
    bus_busy_i = 1'b0;
    cyc("drain_flush", ex(32'hc, 1'b1, VEC, 6'b0, 1'b0, 1'b1));
    cyc("drain_gap", ex(32'h0, 1'b0, 32'h0, 6'b0, 1'b0, 1'b1));
    cyc("drain_idle", z);

    // Latched interrupt survives its source dropping; new flags ignored.
    status_i = 32'hFF01; cause_i = 32'h400; mem_valid_i = 1'b1; bus_busy_i = 1'b1;
    cyc("latch_enter", z);
    status_i = 32'h0; cause_i = 32'h0; exc_flags_i = 5'b00010;
    cyc("latch_hold", ex(32'h0, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b1));
    bus_busy_i = 1'b0;
    cyc("latch_flush", ex(32'h1, 1'b1, VEC, 6'b0, 1'b0, 1'b1));
    clear_inputs();
    cyc("latch_gap", ex(32'h0, 1'b0, 32'h0, 6'b0, 1'b0, 1'b1));

    // Latched eret target survives EPC changing mid-drain.
    exc_flags_i = 5'b10000; mem_valid_i = 1'b1; epc_i = 32'h80003000; bus_busy_i = 1'b1;
    cyc("eret_enter", z);
    clear_inputs();
    cyc("eret_hold", ex(32'h0, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b1));
    bus_busy_i = 1'b0;
    cyc("eret_flush", ex(32'he, 1'b1, 32'h80003000, 6'b0, 1'b0, 1'b1));
    cyc("eret_gap", ex(32'h0, 1'b0, 32'h0, 6'b0, 1'b0, 1'b1));

    // Syscall with the bus stuck: abort at counter 4, flush next cycle.
    exc_flags_i = 5'b00001; mem_valid_i = 1'b1; bus_busy_i = 1'b1;
    cyc("abort_enter", z);
    clear_inputs();
    for (int i = 0; i < 4; i++)
      cyc($sformatf("abort_cnt%0d", i), ex(32'h0, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b1));
    cyc("abort_pulse", ex(32'h0, 1'b0, 32'h0, 6'b011111, 1'b1, 1'b1));
    cyc("abort_flush", ex(32'h8, 1'b1, VEC, 6'b0, 1'b0, 1'b1));
    cyc("abort_gap", ex(32'h0, 1'b0, 32'h0, 6'b0, 1'b0, 1'b1));
    cyc("abort_idle", z);
    bus_busy_i = 1'b0;

    // Reset during DRAIN returns to IDLE without a flush.
    exc_flags_i = 5'b01000; mem_valid_i = 1'b1; bus_busy_i = 1'b1;
    cyc("rstd_enter", z);
    clear_inputs();
    cyc("rstd_hold", ex(32'h0, 1'b0, 32'h0, 6'b011111, 1'b0, 1'b1));
    rst = 1'b1;
    cyc("rstd_assert", z);
    rst = 1'b0; bus_busy_i = 1'b0;
    cyc("rstd_release", z);
    cyc("rstd_quiet", z);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
